// File: rtl/sisc_pkg.sv
// Shared SISC definitions: default address width, HLT opcode, fetch FSM states.
package sisc_pkg;

  localparam int unsigned SISC_ADDR_W  = 16;
  localparam int unsigned SISC_INSTR_W = 32;
  localparam logic [3:0]  OP_HLT       = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  // True when the word carries the HLT opcode in its top nibble.
  function automatic logic is_hlt(input logic [SISC_INSTR_W-1:0] word);
    return word[31:28] == OP_HLT;
  endfunction

endpackage

// File: rtl/sisc_ifetch_fifo.sv
// Prefetch queue: small synchronous FIFO with flush, registered count/flags.
module sisc_ifetch_fifo #(
  parameter int unsigned     WIDTH     = 48,
  parameter int unsigned     DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_f,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_en;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state for storage, pointers and occupancy; flush discards everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_en   = pop & ~empty_q;
    push_en  = push & (~full_q | pop_en);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_en) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_f) begin
      mem_q    <= '{default: RESET_VAL};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/sisc_ifetch.sv
// SISC instruction fetch: PC, single-outstanding memory handshake, prefetch
// queue and branch redirect. Optional HLT detection via SISC_IFETCH_HALT_DETECT_EN.
module sisc_ifetch
  import sisc_pkg::*;
#(
  parameter int unsigned ADDR_W     = SISC_ADDR_W,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic              clk,
  input  logic              rst_f,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              halted
);

  localparam int unsigned ENTRY_W = ADDR_W + SISC_INSTR_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0]  PC_RST    = ADDR_W'(RESET_PC);
  localparam logic [ENTRY_W-1:0] ENTRY_RST = {PC_RST, 32'h0};

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
`ifdef SISC_IFETCH_HALT_DETECT_EN
  logic              halted_q, halted_d;
`endif

  logic              ack_v;
  logic              push;
  logic              pop;
  logic              flush;
  logic [CNT_W-1:0]  count_nxt;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;

  assign ack_v = imem_ack & req_q;

  sisc_ifetch_fifo #(
    .WIDTH     (ENTRY_W),
    .DEPTH     (FIFO_DEPTH),
    .RESET_VAL (ENTRY_RST)
  ) u_fifo (
    .clk   (clk),
    .rst_f (rst_f),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({pc_q, imem_rdata}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Fetch FSM: ack handling, redirect, then request issue for the next cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    push    = 1'b0;
    flush   = 1'b0;
    pop     = instr_valid & instr_ready;
`ifdef SISC_IFETCH_HALT_DETECT_EN
    halted_d = halted_q;
`endif

    case (state_q)
      ST_WAIT: begin
        if (ack_v && !br_taken) begin
          push    = ~fifo_full | pop;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_RUN;
`ifdef SISC_IFETCH_HALT_DETECT_EN
          if (is_hlt(imem_rdata)) state_d = ST_HALT;
`endif
        end
      end
      ST_DROP: begin
        if (ack_v) state_d = ST_RUN;
      end
`ifdef SISC_IFETCH_HALT_DETECT_EN
      ST_HALT: begin
        if (pop && is_hlt(instruction)) halted_d = 1'b1;
      end
`endif
      default: ;
    endcase

    // Redirect: drop queued words; an unacked request must be drained first.
    if (br_taken) begin
      flush = 1'b1;
      pc_d  = br_target;
      if ((state_q == ST_WAIT || state_q == ST_DROP) && !ack_v) begin
        state_d = ST_DROP;
      end else begin
        state_d = ST_RUN;
      end
`ifdef SISC_IFETCH_HALT_DETECT_EN
      halted_d = 1'b0;
`endif
    end

    count_nxt = flush ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
    if (state_d == ST_RUN && count_nxt < CNT_W'(FIFO_DEPTH)) begin
      state_d = ST_WAIT;
      addr_d  = pc_d;
    end
    req_d = (state_d == ST_WAIT) || (state_d == ST_DROP);
  end

  // FSM and output registers; reset restarts fetch at RESET_PC with no request.
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q  <= ST_RUN;
      pc_q     <= PC_RST;
      addr_q   <= PC_RST;
      req_q    <= 1'b0;
`ifdef SISC_IFETCH_HALT_DETECT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
`ifdef SISC_IFETCH_HALT_DETECT_EN
      halted_q <= halted_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = ~fifo_empty;
  assign instr_pc    = fifo_rdata[ENTRY_W-1:SISC_INSTR_W];
  assign instruction = fifo_rdata[SISC_INSTR_W-1:0];
`ifdef SISC_IFETCH_HALT_DETECT_EN
  assign halted      = halted_q;
`else
  assign halted      = 1'b0;
`endif

endmodule
